// File: rtl/ntt_mult_arbiter_if.sv
// Requester-side and engine-side bus of the shared NTT multiplier arbiter.
// The slave modport is the arbiter's view; master is the requesters plus engine.
interface ntt_mult_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            go;
    logic [NUM_REQ-1:0]            req_load_coeff;
    logic [NUM_REQ-1:0]            req_load_sel;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_load_addr;
    logic [NUM_REQ*WIDTH-1:0]      req_load_data;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_read_addr;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            job_done;
    logic                          timeout_err;
    logic [WIDTH-1:0]              rd_data;

    logic                          eng_start;
    logic                          eng_load_coeff;
    logic                          eng_load_sel;
    logic [ADDR_WIDTH-1:0]         eng_load_addr;
    logic [WIDTH-1:0]              eng_load_data;
    logic [ADDR_WIDTH-1:0]         eng_read_addr;
    logic                          eng_done;
    logic                          eng_busy;
    logic [WIDTH-1:0]              eng_read_data;

    modport slave (
        input  req, go, req_load_coeff, req_load_sel, req_load_addr, req_load_data, req_read_addr,
        output gnt, job_done, timeout_err, rd_data,
        output eng_start, eng_load_coeff, eng_load_sel, eng_load_addr, eng_load_data, eng_read_addr,
        input  eng_done, eng_busy, eng_read_data
    );

    modport master (
        output req, go, req_load_coeff, req_load_sel, req_load_addr, req_load_data, req_read_addr,
        input  gnt, job_done, timeout_err, rd_data,
        input  eng_start, eng_load_coeff, eng_load_sel, eng_load_addr, eng_load_data, eng_read_addr,
        output eng_done, eng_busy, eng_read_data
    );
endinterface

// File: rtl/ntt_mult_arbiter.sv
// Round-robin owner arbitration for one shared ntt_poly_mult engine, with
// per-owner load/read muxing, start/done sequencing and a RUN watchdog.
module ntt_mult_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    ntt_mult_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RUN, S_RESULT} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               terr_q, terr_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [IDX_W-1:0]   cand, pick;
    logic               found;
    logic               own_req, own_go;
    logic               in_grant, in_result;

    assign own_req   = bus.req[owner_q];
    assign own_go    = bus.go[owner_q];
    assign in_grant  = (state_q == S_GRANT);
    assign in_result = (state_q == S_RESULT);

    // Search starts one past the previous owner and wraps.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        terr_d  = terr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d     = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    terr_d      = 1'b0;
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!own_req) begin
                    gnt_d   = '0;
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end else if (own_go && !bus.eng_busy) begin
                    // Never restart an engine that has not yet returned to idle.
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                if ({1'b0, cnt_q} + 17'd1 >= 17'(TIMEOUT)) terr_d = 1'b1;
                if (bus.eng_done) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = S_RESULT;
                end
            end
            S_RESULT: begin
                if (!own_req) begin
                    gnt_d   = '0;
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.job_done    = done_q;
    assign bus.timeout_err = terr_q;
    assign bus.rd_data     = bus.eng_read_data;

    // Start is a level for the whole RUN; dropping it in RESULT lets the engine exit done.
    assign bus.eng_start      = (state_q == S_RUN);
    assign bus.eng_load_coeff = in_grant & bus.req_load_coeff[owner_q];
    assign bus.eng_load_sel   = in_grant & bus.req_load_sel[owner_q];
    assign bus.eng_load_addr  = in_grant ? bus.req_load_addr[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.eng_load_data  = in_grant ? bus.req_load_data[int'(owner_q)*WIDTH +: WIDTH] : '0;
    assign bus.eng_read_addr  = in_result ? bus.req_read_addr[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
endmodule

// File: tb/tb_ntt_mult_arbiter.sv
// Directed bench for ntt_mult_arbiter with a behavioural negacyclic multiplier engine.
module tb_ntt_mult_arbiter;
    localparam int NR = 4, W = 32, AW = 8, N = 256, TO = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ntt_mult_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();
    ntt_mult_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Engine model: start level -> fixed latency -> done held until start drops.
    logic [W-1:0] mem_a [N];
    logic [W-1:0] mem_b [N];
    logic [W-1:0] res   [N];
    logic         e_run, e_done, hang;
    logic [3:0]   e_cnt;

    assign bus.eng_done      = e_done;
    assign bus.eng_busy      = e_run | e_done;
    assign bus.eng_read_data = res[bus.eng_read_addr];

    function automatic logic [W-1:0] conv(int k);
        logic [W-1:0] acc;
        logic [7:0]   j;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            if (mem_a[8'(i)] != '0) begin
                j = 8'(k - i);
                if (i <= k) acc = acc + mem_a[8'(i)] * mem_b[j];
                else        acc = acc - mem_a[8'(i)] * mem_b[j];
            end
        end
        return acc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_run  <= 1'b0;
            e_done <= 1'b0;
            e_cnt  <= '0;
        end else begin
            if (bus.eng_load_coeff) begin
                if (bus.eng_load_sel) mem_b[bus.eng_load_addr] <= bus.eng_load_data;
                else                  mem_a[bus.eng_load_addr] <= bus.eng_load_data;
            end
            if (e_done) begin
                if (!bus.eng_start) e_done <= 1'b0;
            end else if (e_run) begin
                if (e_cnt != 4'd0) e_cnt <= e_cnt - 4'd1;
                else if (!hang) begin
                    for (int k = 0; k < N; k++) res[8'(k)] <= conv(k);
                    e_done <= 1'b1;
                    e_run  <= 1'b0;
                end
            end else if (bus.eng_start) begin
                e_run <= 1'b1;
                e_cnt <= 4'd4;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(int r, logic lc, logic sel, logic [AW-1:0] a, logic [W-1:0] d);
        bus.req_load_coeff[r]         = lc;
        bus.req_load_sel[r]           = sel;
        bus.req_load_addr[r*AW +: AW] = a;
        bus.req_load_data[r*W +: W]   = d;
    endtask

    task automatic wait_jd(int r, output int seen);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.job_done[r]) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic start_job(int r);
        bus.go[r] = 1'b1;
        tick();
        bus.go[r] = 1'b0;
    endtask

    typedef struct {
        logic [NR-1:0]    lc, ls;
        logic [NR*AW-1:0] la;
        logic [NR*W-1:0]  ld;
        logic             e_lc, e_ls;
        logic [AW-1:0]    e_la;
        logic [W-1:0]     e_ld;
    } vec_t;

    vec_t vt [5];
    logic [NR-1:0] rr_exp [5];
    logic [W-1:0]  rd_exp1 [4];
    logic [W-1:0]  rd_exp2 [3];

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen, njd;
        logic [NR-1:0] other;

        // Owner is requester 1; requester 2 (and later 0/3) push 0xDEAD-style noise.
        vt[0] = '{4'b0110, 4'b0100, {8'h00, 8'h00, 8'h00, 8'h00}, {32'h0, 32'hDEAD, 32'd3, 32'h0}, 1'b1, 1'b0, 8'h00, 32'd3};
        vt[1] = '{4'b0100, 4'b0100, {8'h00, 8'h01, 8'h05, 8'h00}, {32'h0, 32'hDEAD, 32'd7, 32'h0}, 1'b0, 1'b0, 8'h05, 32'd7};
        vt[2] = '{4'b0110, 4'b0100, {8'h00, 8'h00, 8'h01, 8'h00}, {32'h0, 32'hDEAD, 32'd1, 32'h0}, 1'b1, 1'b0, 8'h01, 32'd1};
        vt[3] = '{4'b0110, 4'b0010, {8'h00, 8'h01, 8'h00, 8'h00}, {32'h0, 32'hDEAD, 32'd2, 32'h0}, 1'b1, 1'b1, 8'h00, 32'd2};
        vt[4] = '{4'b1001, 4'b1011, {8'h33, 8'h00, 8'h09, 8'h44}, {32'hBEEF, 32'h0, 32'h55, 32'hCAFE}, 1'b0, 1'b1, 8'h09, 32'h55};
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        // (1+x)^2 and, with B[1]=1 retained, (3+x)(2+x)
        rd_exp1 = '{32'd1, 32'd2, 32'd1, 32'd0};
        rd_exp2 = '{32'd6, 32'd5, 32'd1};

        for (int i = 0; i < N; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            res[i]   = '0;
        end
        hang = 1'b0;
        bus.req = '0; bus.go = '0; bus.req_load_coeff = '0; bus.req_load_sel = '0;
        bus.req_load_addr = '0; bus.req_load_data = '0; bus.req_read_addr = '0;

        // Reset state
        #12;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_job_done", bus.job_done, 0);
        chk("rst_timeout", bus.timeout_err, 0);
        chk("rst_eng_start", bus.eng_start, 0);
        chk("rst_eng_load", {bus.eng_load_coeff, bus.eng_load_sel, bus.eng_load_addr, bus.eng_load_data}, 0);
        chk("rst_eng_raddr", bus.eng_read_addr, 0);
        rst_n = 1'b1;
        tick();

        // Single requester job
        bus.req[0] = 1'b1;
        #1 chk("single_gnt_before", bus.gnt, 0);
        tick();
        chk("single_gnt", bus.gnt, 4'b0001);
        bus.req_read_addr = {8'd7, 8'd7, 8'd7, 8'd3};
        #1 chk("grant_raddr_zero", bus.eng_read_addr, 0);
        set_load(0, 1'b1, 1'b0, 8'd0, 32'd1); tick();
        set_load(0, 1'b1, 1'b0, 8'd1, 32'd1); tick();
        set_load(0, 1'b1, 1'b1, 8'd0, 32'd1); tick();
        set_load(0, 1'b1, 1'b1, 8'd1, 32'd1);
        #1 chk("single_load_comb", {bus.eng_load_coeff, bus.eng_load_sel, bus.eng_load_addr}, {1'b1, 1'b1, 8'd1});
        tick();
        set_load(0, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("grant_no_start", bus.eng_start, 0);
        start_job(0);
        chk("single_start", bus.eng_start, 1);
        chk("run_load_off", bus.eng_load_coeff, 0);
        njd = 0; other = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.job_done[0]) njd++;
            other |= bus.job_done & 4'b1110;
        end
        chk("single_jd_count", njd, 1);
        chk("single_jd_other", other, 0);
        chk("result_start_low", bus.eng_start, 0);
        for (int a = 0; a < 4; a++) begin
            bus.req_read_addr[0 +: AW] = AW'(a);
            #1 chk($sformatf("single_rd%0d", a), bus.rd_data, rd_exp1[a]);
        end
        chk("result_raddr", bus.eng_read_addr, 8'd3);
        bus.req[0] = 1'b0;
        tick();
        chk("single_release", bus.gnt, 0);

        // Round-robin from fresh reset
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_gnt%0d", k), bus.gnt, rr_exp[k]);
            if (k < 4) begin
                start_job(k);
                wait_jd(k, seen);
                chk($sformatf("rr_jd%0d", k), seen, 1);
                bus.req[k] = 1'b0;
                tick();
                chk($sformatf("rr_idle%0d", k), bus.gnt, 0);
                bus.req[k] = 1'b1;
            end
        end
        bus.req = '0;
        tick();
        chk("rr_abort_all", bus.gnt, 0);

        // Isolation: requester 1 owns, others drive load strobes
        bus.req[1] = 1'b1;
        tick();
        chk("iso_gnt", bus.gnt, 4'b0010);
        for (int v = 0; v < 5; v++) begin
            bus.req_load_coeff = vt[v].lc;
            bus.req_load_sel   = vt[v].ls;
            bus.req_load_addr  = vt[v].la;
            bus.req_load_data  = vt[v].ld;
            #1;
            chk($sformatf("iso_v%0d", v),
                {bus.eng_load_coeff, bus.eng_load_sel, bus.eng_load_addr, bus.eng_load_data},
                {vt[v].e_lc, vt[v].e_ls, vt[v].e_la, vt[v].e_ld});
            tick();
        end
        bus.req_load_coeff = '0; bus.req_load_sel = '0;
        bus.req_load_addr = '0; bus.req_load_data = '0;
        start_job(1);
        wait_jd(1, seen);
        chk("iso_jd", seen, 1);
        for (int a = 0; a < 3; a++) begin
            bus.req_read_addr = {8'd9, 8'd9, AW'(a), 8'd9};
            #1 chk($sformatf("iso_rd%0d", a), bus.rd_data, rd_exp2[a]);
        end
        bus.req[1] = 1'b0;
        tick();

        // Abort in GRANT without go, then abort racing go
        bus.req[3] = 1'b1;
        tick();
        chk("abort_gnt", bus.gnt, 4'b1000);
        bus.req[3] = 1'b0;
        tick();
        chk("abort_idle", {bus.gnt, bus.eng_start}, 0);
        tick();
        chk("abort_no_jd", {bus.job_done, bus.eng_start}, 0);
        bus.req[2] = 1'b1;
        tick();
        chk("race_gnt", bus.gnt, 4'b0100);
        bus.go[2] = 1'b1;
        bus.req[2] = 1'b0;
        tick();
        bus.go[2] = 1'b0;
        chk("race_abort_wins", {bus.gnt, bus.eng_start}, 0);
        tick();
        chk("race_no_start", {bus.eng_start, bus.job_done}, 0);

        // Release during RUN
        bus.req[0] = 1'b1;
        tick();
        chk("rrun_gnt", bus.gnt, 4'b0001);
        start_job(0);
        bus.req[0] = 1'b0;
        tick();
        chk("rrun_hold", {bus.gnt, bus.eng_start}, {4'b0001, 1'b1});
        wait_jd(0, seen);
        chk("rrun_jd", seen, 1);
        chk("rrun_result_gnt", bus.gnt, 4'b0001);
        tick();
        chk("rrun_idle", {bus.gnt, bus.job_done}, 0);

        // Watchdog
        bus.req[1] = 1'b1;
        tick();
        chk("wd_gnt", bus.gnt, 4'b0010);
        hang = 1'b1;
        start_job(1);
        chk("wd_run0", bus.timeout_err, 0);
        for (int c = 0; c < 9; c++) tick();
        chk("wd_early", bus.timeout_err, 0);
        tick();
        chk("wd_set", bus.timeout_err, 1);
        for (int c = 0; c < 5; c++) tick();
        chk("wd_sticky", {bus.timeout_err, bus.eng_start}, 2'b11);
        hang = 1'b0;
        wait_jd(1, seen);
        chk("wd_jd", seen, 1);
        chk("wd_result_sticky", bus.timeout_err, 1);
        bus.req[1] = 1'b0;
        tick();
        chk("wd_idle_sticky", {bus.gnt, bus.timeout_err}, {4'b0000, 1'b1});
        bus.req[1] = 1'b1;
        tick();
        chk("wd_clear_on_grant", {bus.gnt, bus.timeout_err}, {4'b0010, 1'b0});

        // Hung job, then asynchronous reset mid-RUN
        hang = 1'b1;
        start_job(1);
        for (int c = 0; c < 12; c++) tick();
        chk("wd_set2", bus.timeout_err, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {bus.gnt, bus.eng_start, bus.timeout_err}, 0);
        bus.req = '0;
        hang = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {bus.gnt, bus.job_done}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ntt_mult_arbiter.md
# ntt_mult_arbiter

Round-robin arbiter and sequencer that shares one `ntt_poly_mult` engine between NUM_REQ independent requesters. It sits between the requesters and the engine and grants exclusive ownership of the engine to one requester at a time. During ownership it muxes that requester's load and read ports onto the engine and drives the engine's level-sensitive start/done handshake on the requester's behalf. It also reports per-requester job completion and a run-time watchdog flag.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 32: coefficient width; must match the engine.
- ADDR_WIDTH, 8: coefficient address width; must match the engine.
- TIMEOUT, 65535: watchdog limit on RUN cycles, ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester ownership request, level; held high for the whole job.
- go  in  NUM_REQ  per-requester start-multiply strobe; honoured only from the owner in GRANT.
- req_load_coeff  in  NUM_REQ  per-requester coefficient write enable.
- req_load_sel  in  NUM_REQ  per-requester operand select: 0=A, 1=B.
- req_load_addr  in  NUM_REQ*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_load_data  in  NUM_REQ*WIDTH  requester i at [i*WIDTH +: WIDTH].
- req_read_addr  in  NUM_REQ*ADDR_WIDTH  result read address, packed the same way.
- gnt  out  NUM_REQ  one-hot ownership, registered.
- job_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- timeout_err  out  1  sticky watchdog flag; cleared at the next grant.
- rd_data  out  WIDTH  engine read data, broadcast to all requesters.
- eng_start, eng_load_coeff, eng_load_sel  out  1  engine controls.
- eng_load_addr, eng_read_addr  out  ADDR_WIDTH  engine addresses.
- eng_load_data  out  WIDTH  engine load data.
- eng_done, eng_busy  in  1  engine status.
- eng_read_data  in  WIDTH  engine result data.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner loads A and B operands.
  - RUN: engine multiplying.
  - RESULT: owner reads the result.
- IDLE:
  - Pick the first asserted req, searching from (last_owner+1) mod NUM_REQ upward with wrap-around.
  - Register the owner index, set gnt[owner], clear timeout_err, and go to GRANT.
  - last_owner resets to NUM_REQ-1, so requester 0 wins first.
- GRANT:
  - eng_load_* = owner's load slice.
  - Non-owner load strobes are ignored; they never reach the engine.
  - Owner's go → RUN.
  - Owner's req low → IDLE; engine is never started.
  - If go and req drop in the same cycle, the abort wins.
- RUN:
  - eng_start=1 and eng_load_coeff=0.
  - On eng_done=1: pulse job_done[owner] and go to RESULT.
  - req is ignored in RUN; an in-flight job always completes.
  - A saturating 16-bit cycle counter starts at 0 on RUN entry. When it reaches TIMEOUT, set timeout_err and keep waiting (the engine has no abort).
- RESULT:
  - eng_start=0, so the engine returns to its idle state and its result stays readable.
  - eng_read_addr = owner's read slice; rd_data = eng_read_data, combinational.
  - Owner's req low → IDLE: clear gnt, set last_owner = owner.
  - If the owner's req is already low on entry, leave after exactly one RESULT cycle.
- Outside GRANT, eng_load_coeff=0. Outside RESULT, eng_read_addr=0.
- The engine retains A/B input memories between jobs, so each owner must load all N coefficients of both operands.
- gnt is always one-hot or zero, and never changes outside IDLE→GRANT and RESULT/GRANT→IDLE.

## Timing
- Reset values:
  - state=IDLE, gnt=0, job_done=0, timeout_err=0, eng_start=0, eng_load_coeff=0, eng_load_sel=0.
  - eng_load_addr=0, eng_load_data=0, eng_read_addr=0, last_owner=NUM_REQ-1, counter=0.
- Reset mid-job: returns to IDLE immediately and drops eng_start.
  - The engine shares rst_n, so it resets too.
- Grant latency: req high at edge t → gnt high after edge t+1.
- Handover dead time: release at edge t → IDLE; next gnt after edge t+2.
- Load path is combinational: the owner's load strobe reaches the engine in the same cycle.
- go sampled at edge t → eng_start high after edge t; job_done pulses in the cycle after eng_done is first seen.
- eng_start is a level. It drops in the first RESULT cycle, which satisfies the engine's start-low-to-exit-done rule.

## Test plan
- Single requester:
  - Stimulus: req[0]=1; load A=[1,1,0…], B=[1,1,0…] (N=256); go.
  - Response: gnt=0001 one cycle after req; job_done[0] pulses once; read addr 0,1,2 → 1,2,1; all others 0.
- Round-robin:
  - Stimulus: req=1111 held; each owner runs a job and releases.
  - Response: gnt sequence 0001,0010,0100,1000,0001; exactly one IDLE cycle between grants.
- Isolation:
  - Stimulus: while requester 1 owns in GRANT, requester 2 drives load_coeff with data 0xDEAD.
  - Response: eng_load_coeff follows requester 1 only; result uncorrupted.
- Abort:
  - Stimulus: owner drops req in GRANT without go.
  - Response: eng_start never asserts; IDLE next cycle; no job_done.
- Release during RUN:
  - Stimulus: owner drops req mid-RUN.
  - Response: engine completes; job_done pulses; one RESULT cycle, then IDLE.
- Watchdog and reset:
  - Stimulus: TIMEOUT=10 with engine eng_done tied 0; then assert rst_n low.
  - Response: timeout_err rises after 10 RUN cycles and stays set; reset clears gnt, eng_start and timeout_err asynchronously.
